// File: rtl/fp_post_normalizer.sv
// fp_post_normalizer
//   Post-normalization stage for a floating-point adder/subtractor. Takes the
//   raw sum (carry, hidden and fraction bits) with its biased exponent. A
//   carry-out is folded back with a right shift. Leading zeros are removed
//   with one left shift per cycle until the hidden bit is set or the
//   exponent bottoms out. The result is then held behind a valid/ready
//   handshake.
//
// Ports
//   Clk, RstN      clock, asynchronous active-low reset
//   InValid/InReady  operand handshake (InReady high only while idle)
//   InSign, InExponent, InMantissa  raw result; InMantissa =
//                    {carry, hidden, fraction[MantissaSize-1:0]}
//   OutValid/OutReady  result handshake; outputs held until accepted
//   OutSign, OutExponent, OutMantissa  normalized result (hidden bit dropped)
//   Overflow, Underflow, Zero  one-hot-or-none result flags
//   OutGuard       bit lost by the carry right shift (only when
//                  FP_NORM_GUARD_BIT_EN is defined)
//
// Configuration
//   FP_NORM_GUARD_BIT_EN  adds the OutGuard output.

module fp_post_normalizer #(
  parameter int ExponentSize = 8,
  parameter int MantissaSize = 23
) (
  input  logic                    Clk,
  input  logic                    RstN,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic                    InSign,
  input  logic [ExponentSize-1:0] InExponent,
  input  logic [MantissaSize+1:0] InMantissa,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic                    OutSign,
  output logic [ExponentSize-1:0] OutExponent,
  output logic [MantissaSize-1:0] OutMantissa,
  output logic                    Overflow,
  output logic                    Underflow,
  output logic                    Zero
`ifdef FP_NORM_GUARD_BIT_EN
  ,
  output logic                    OutGuard
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    SHIFT,
    DONE
  } stateT;

  localparam logic [ExponentSize-1:0] ExpMax = '1;
  localparam logic [ExponentSize-1:0] ExpOne = ExponentSize'(1);

  stateT state, nextState;

  // Working copy of the operand, modified in place while normalizing.
  logic                    wSign;
  logic [ExponentSize-1:0] wExp;
  logic [MantissaSize+1:0] wMant;
  logic                    wOverflow, wUnderflow, wZero;

  logic                    accept;
  logic                    loadOut;
  logic                    mantZero, carryBit, hiddenBit, expZero, expOne;
  logic [ExponentSize-1:0] expInc;

  assign accept    = InValid && InReady;
  // Output registers load on the first DONE cycle; OutValid follows one
  // cycle after the working registers settle.
  assign loadOut   = (state == DONE) && !OutValid;
  assign mantZero  = (wMant == '0);
  assign carryBit  = wMant[MantissaSize+1];
  assign hiddenBit = wMant[MantissaSize];
  assign expZero   = (wExp == '0);
  assign expOne    = (wExp == ExpOne);
  // Saturating increment: an exponent already at all ones stays there.
  assign expInc    = (wExp == ExpMax) ? ExpMax : wExp + ExpOne;

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    // NOTE: defaults come first so every path assigns every output of this
    // block; a missing assignment on some branch would infer a latch.
    nextState = state;
    InReady   = 1'b0;
    case (state)
      IDLE: begin
        InReady = 1'b1;
        if (InValid) nextState = CHECK;
      end
      CHECK: begin
        if (mantZero || carryBit || hiddenBit || expZero) nextState = DONE;
        else                                              nextState = SHIFT;
      end
      SHIFT: begin
        if (hiddenBit || expOne) nextState = DONE;
      end
      DONE: begin
        if (OutValid && OutReady) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      wSign       <= 1'b0;
      wExp        <= '0;
      wMant       <= '0;
      wOverflow   <= 1'b0;
      wUnderflow  <= 1'b0;
      wZero       <= 1'b0;
      OutValid    <= 1'b0;
      OutSign     <= 1'b0;
      OutExponent <= '0;
      OutMantissa <= '0;
      Overflow    <= 1'b0;
      Underflow   <= 1'b0;
      Zero        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            wSign      <= InSign;
            wExp       <= InExponent;
            wMant      <= InMantissa;
            wOverflow  <= 1'b0;
            wUnderflow <= 1'b0;
            wZero      <= 1'b0;
          end
        end
        CHECK: begin
          if (mantZero) begin
            wExp  <= '0;
            wZero <= 1'b1;
          end else if (carryBit) begin
            wExp <= expInc;
            if (expInc == ExpMax) begin
              // Infinity: fraction forced to zero.
              wOverflow <= 1'b1;
              wMant     <= '0;
            end else begin
              wMant <= wMant >> 1;
            end
          end else if (!hiddenBit && expZero) begin
            // Already subnormal; nothing to normalize.
            wUnderflow <= 1'b1;
          end
        end
        SHIFT: begin
          if (!hiddenBit) begin
            if (expOne) begin
              // Cannot go below the smallest normal exponent: becomes subnormal
              // without consuming the shift.
              wExp       <= '0;
              wUnderflow <= 1'b1;
            end else begin
              wMant <= wMant << 1;
              wExp  <= wExp - ExpOne;
            end
          end
        end
        DONE: begin
          if (loadOut) begin
            OutValid    <= 1'b1;
            OutSign     <= wSign;
            OutExponent <= wExp;
            OutMantissa <= wMant[MantissaSize-1:0];
            Overflow    <= wOverflow;
            Underflow   <= wUnderflow;
            Zero        <= wZero;
          end else if (OutReady) begin
            OutValid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FP_NORM_GUARD_BIT_EN
  logic wGuard;

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      wGuard   <= 1'b0;
      OutGuard <= 1'b0;
    end else begin
      if (accept)                            wGuard <= 1'b0;
      else if ((state == CHECK) && carryBit) wGuard <= wMant[0];
      if (loadOut) OutGuard <= wGuard;
    end
  end
`endif

endmodule

// File: tb/tb_fp_post_normalizer.sv
// Scoreboard bench for fp_post_normalizer (ExponentSize=8, MantissaSize=23).
// Directed vectors carry hand-computed results and latencies; the driver
// pushes each accepted operand, the monitor pops and compares on handshake.

module tb_fp_post_normalizer;

  localparam int Es = 8;
  localparam int Ms = 23;

  typedef struct {
    logic          s;
    logic [Es-1:0] e;
    logic [Ms+1:0] m;
    logic [Es-1:0] xe;
    logic [Ms-1:0] xm;
    logic          ovf;
    logic          udf;
    logic          zero;
    logic          guard;
    int            lat;
  } vecT;

  typedef struct {
    vecT v;
    int  idx;
    int  acceptCycle;
  } sbItemT;

  logic          Clk = 1'b0;
  logic          RstN = 1'b0;
  logic          InValid = 1'b0;
  logic          InReady;
  logic          InSign = 1'b0;
  logic [Es-1:0] InExponent = '0;
  logic [Ms+1:0] InMantissa = '0;
  logic          OutValid;
  logic          OutReady = 1'b1;
  logic          OutSign;
  logic [Es-1:0] OutExponent;
  logic [Ms-1:0] OutMantissa;
  logic          Overflow, Underflow, Zero;
`ifdef FP_NORM_GUARD_BIT_EN
  logic          OutGuard;
`endif

  int     tests = 0;
  int     fails = 0;
  int     cycleCnt = 0;
  sbItemT sb[$];
  vecT    vecs[$];

  fp_post_normalizer #(.ExponentSize(Es), .MantissaSize(Ms)) dut (
    .Clk        (Clk),
    .RstN       (RstN),
    .InValid    (InValid),
    .InReady    (InReady),
    .InSign     (InSign),
    .InExponent (InExponent),
    .InMantissa (InMantissa),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .OutSign    (OutSign),
    .OutExponent(OutExponent),
    .OutMantissa(OutMantissa),
    .Overflow   (Overflow),
    .Underflow  (Underflow),
    .Zero       (Zero)
`ifdef FP_NORM_GUARD_BIT_EN
    ,
    .OutGuard   (OutGuard)
`endif
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cycleCnt <= cycleCnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outWord();
    return {29'd0, OutSign, OutExponent, OutMantissa, Overflow, Underflow, Zero};
  endfunction

  // Monitor: latency on first OutValid, hold stability while stalled,
  // full compare on the accepting edge.
  initial begin
    sbItemT      cur;
    logic        sawValid;
    logic [63:0] snap;
    sawValid = 1'b0;
    snap = '0;
    forever begin
      @(negedge Clk);
      if (!RstN) begin
        sawValid = 1'b0;
      end else if (OutValid) begin
        check("in_ready while output valid", {63'd0, InReady}, 64'd0);
        if (!sawValid) begin
          sawValid = 1'b1;
          snap = outWord();
          if (sb.size() == 0) begin
            check("out_valid with no operand in flight", {63'd0, OutValid}, 64'd0);
          end else begin
            cur = sb[0];
            check($sformatf("v%0d latency", cur.idx),
                  64'(cycleCnt - cur.acceptCycle), 64'(cur.v.lat));
          end
        end else begin
          check("outputs stable while stalled", outWord(), snap);
        end
        if (OutReady) begin
          sawValid = 1'b0;
          if (sb.size() > 0) begin
            cur = sb.pop_front();
            check($sformatf("v%0d sign", cur.idx), {63'd0, OutSign}, {63'd0, cur.v.s});
            check($sformatf("v%0d exponent", cur.idx), 64'(OutExponent), 64'(cur.v.xe));
            check($sformatf("v%0d mantissa", cur.idx), 64'(OutMantissa), 64'(cur.v.xm));
            check($sformatf("v%0d flags ovf/udf/zero", cur.idx),
                  {61'd0, Overflow, Underflow, Zero},
                  {61'd0, cur.v.ovf, cur.v.udf, cur.v.zero});
`ifdef FP_NORM_GUARD_BIT_EN
            check($sformatf("v%0d guard", cur.idx), {63'd0, OutGuard}, {63'd0, cur.v.guard});
`endif
          end
        end
      end
    end
  end

  task automatic sendOp(input vecT v, input int idx);
    sbItemT item;
    int     budget;
    @(posedge Clk); #1;
    InValid    = 1'b1;
    InSign     = v.s;
    InExponent = v.e;
    InMantissa = v.m;
    budget = 0;
    while (!InReady && budget < 200) begin
      @(posedge Clk); #1;
      budget++;
    end
    if (!InReady) begin
      check($sformatf("v%0d in_ready timeout", idx), {63'd0, InReady}, 64'd1);
      InValid = 1'b0;
      return;
    end
    @(posedge Clk); #1;
    item.v = v;
    item.idx = idx;
    item.acceptCycle = cycleCnt;
    sb.push_back(item);
    // Busy now: scrambled inputs with InValid still high must be ignored.
    InSign     = ~v.s;
    InExponent = Es'($urandom);
    InMantissa = (Ms+2)'($urandom);
    @(posedge Clk); #1;
    InValid = 1'b0;
  endtask

  task automatic waitDrain();
    int budget;
    budget = 0;
    while (sb.size() != 0 && budget < 200) begin
      @(posedge Clk); #1;
      budget++;
    end
    check("scoreboard drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, " OutValid"}, {63'd0, OutValid}, 64'd0);
    check({tag, " outputs"}, outWord(), 64'd0);
`ifdef FP_NORM_GUARD_BIT_EN
    check({tag, " OutGuard"}, {63'd0, OutGuard}, 64'd0);
`endif
  endtask

  initial begin
    int budget;
    //            s     e      m             xe     xm           ovf   udf   zero  grd   lat
    vecs.push_back('{1'b0, 8'h80, 25'h0800000, 8'h80, 23'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 2});
    vecs.push_back('{1'b1, 8'h7F, 25'h1000001, 8'h80, 23'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 2});
    vecs.push_back('{1'b0, 8'h80, 25'h0000001, 8'h69, 23'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 26});
    vecs.push_back('{1'b0, 8'hFE, 25'h1000000, 8'hFF, 23'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 2});
    vecs.push_back('{1'b1, 8'h03, 25'h0010000, 8'h00, 23'h040000, 1'b0, 1'b1, 1'b0, 1'b0, 5});
    vecs.push_back('{1'b0, 8'h55, 25'h0000000, 8'h00, 23'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 2});
    vecs.push_back('{1'b0, 8'h10, 25'h1800003, 8'h11, 23'h400001, 1'b0, 1'b0, 1'b0, 1'b1, 2});
    vecs.push_back('{1'b1, 8'h00, 25'h0300000, 8'h00, 23'h300000, 1'b0, 1'b1, 1'b0, 1'b0, 2});
    vecs.push_back('{1'b0, 8'h40, 25'h0400001, 8'h3F, 23'h000002, 1'b0, 1'b0, 1'b0, 1'b0, 4});
    vecs.push_back('{1'b1, 8'hFF, 25'h1000000, 8'hFF, 23'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 2});
    vecs.push_back('{1'b0, 8'h02, 25'h0400000, 8'h01, 23'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 4});
    vecs.push_back('{1'b1, 8'h01, 25'h0400000, 8'h00, 23'h400000, 1'b0, 1'b1, 1'b0, 1'b0, 3});

    #1;
    checkAllZero("in reset");
    repeat (2) @(posedge Clk);
    #1 RstN = 1'b1;
    check("in_ready after reset", {63'd0, InReady}, 64'd1);

    foreach (vecs[i]) sendOp(vecs[i], i);
    waitDrain();

    // Back-pressure: result must hold for 5 stalled cycles.
    OutReady = 1'b0;
    sendOp(vecs[6], 100);
    budget = 0;
    while (!OutValid && budget < 50) begin
      @(posedge Clk); #1;
      budget++;
    end
    check("stall: out_valid seen", {63'd0, OutValid}, 64'd1);
    repeat (5) @(posedge Clk);
    #1 OutReady = 1'b1;
    waitDrain();

    // Reset during a long left-shift sequence discards the operation.
    sendOp(vecs[2], 200);
    repeat (4) @(posedge Clk);
    #2 RstN = 1'b0;
    #1;
    checkAllZero("async reset mid-shift");
    sb.delete();
    @(posedge Clk); #1 RstN = 1'b1;
    repeat (40) @(posedge Clk);
    #1;
    checkAllZero("after reset mid-shift");
    check("in_ready after mid-shift reset", {63'd0, InReady}, 64'd1);

    // Normal operation resumes after the aborted operation.
    sendOp(vecs[0], 300);
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_post_normalizer.md
FP_POST_NORMALIZER -- requirements
Module: fp_post_normalizer

Interface
REQ-001 SHALL have parameter ExponentSize, default 8, exponent field width.
REQ-002 SHALL have parameter MantissaSize, default 23, stored fraction width.
REQ-003 SHALL have port Clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port RstN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port InValid  input  1  input operand valid.
REQ-006 SHALL have port InReady  output  1  block can accept an operand.
REQ-007 SHALL have port InSign  input  1  sign of raw add/sub result.
REQ-008 SHALL have port InExponent  input  ExponentSize  biased exponent before normalization.
REQ-009 SHALL have port InMantissa  input  MantissaSize+2  raw sum: [MS+1] carry, [MS] hidden, [MS-1:0] fraction.
REQ-010 SHALL have port OutValid  output  1  normalized result valid.
REQ-011 SHALL have port OutReady  input  1  downstream accepts result.
REQ-012 SHALL have port OutSign  output  1  registered InSign.
REQ-013 SHALL have port OutExponent  output  ExponentSize  normalized biased exponent.
REQ-014 SHALL have port OutMantissa  output  MantissaSize  normalized fraction, hidden bit dropped.
REQ-015 SHALL have ports Overflow, Underflow, Zero  output  1 each  result flags, valid with OutValid.

Function
REQ-016 SHALL implement FSM states IDLE, CHECK, SHIFT, DONE.
REQ-017 IDLE: InReady=1; InValid&InReady captures all inputs into working registers, next state CHECK.
REQ-018 InReady SHALL be 0 in CHECK, SHIFT and DONE; input changes there SHALL be ignored.
REQ-019 CHECK, working mantissa all zero: exponent 0, Zero=1, -> DONE.
REQ-020 CHECK, carry bit 1: mantissa shifted right 1, exponent+1; if new exponent is all ones: Overflow=1, fraction 0, -> DONE; else -> DONE.
REQ-021 CHECK, carry 0 and hidden 1: -> DONE unchanged.
REQ-022 CHECK, carry 0, hidden 0, exponent 0: Underflow=1, -> DONE unchanged (already subnormal).
REQ-023 CHECK, otherwise: -> SHIFT.
REQ-024 SHIFT, each cycle: if hidden 1 -> DONE; else if exponent==1 -> exponent 0, Underflow=1, -> DONE, no shift; else mantissa shifted left 1, exponent-1, stay SHIFT.
REQ-025 Latency: OutValid SHALL assert 2 cycles after acceptance edge when no left shift needed, 3+k cycles after for k left shifts (k<=MantissaSize).
REQ-026 DONE: OutValid=1, all outputs stable until OutValid&OutReady edge, then -> IDLE; no back-to-back accept on that same edge.
REQ-027 At most one of Overflow, Underflow, Zero SHALL be 1 per result; flags cleared on each new acceptance.
REQ-028 Exponent arithmetic SHALL be ExponentSize wide, never wrapping below 0 or above all ones.

Reset
REQ-029 RstN low SHALL immediately force IDLE, InReady=1 after release, OutValid=0, OutSign=0, OutExponent=0, OutMantissa=0, all flags 0.
REQ-030 Reset mid-SHIFT or in DONE SHALL discard the operation with no OutValid pulse.

Configuration
REQ-031 Macro FP_NORM_GUARD_BIT_EN defined: SHALL add output OutGuard (1 bit) holding the bit discarded by the REQ-020 right shift, 0 otherwise, reset 0.
REQ-032 Macro undefined: OutGuard port SHALL be absent; discarded bit dropped; all other behaviour identical.

Verification (ExponentSize=8, MantissaSize=23)
REQ-033 InMantissa=25'h0800000, InExponent=8'h80 -> OutValid 2 cycles after accept, OutExponent=8'h80, OutMantissa=0, no flags.
REQ-034 InMantissa=25'h1000001, InExponent=8'h7F -> OutExponent=8'h80, OutMantissa=0, OutGuard=1 (macro on).
REQ-035 InMantissa=25'h0000001, InExponent=8'h80 -> 23 shifts, OutExponent=8'h69, OutMantissa=0, OutValid 26 cycles after accept.
REQ-036 InMantissa=25'h1000000, InExponent=8'hFE -> OutExponent=8'hFF, OutMantissa=0, Overflow=1.
REQ-037 InMantissa=25'h0010000, InExponent=8'h03 -> OutExponent=0, OutMantissa=23'h040000, Underflow=1; InMantissa=0 -> Zero=1, OutExponent=0.
REQ-038 OutReady held 0 for 5 cycles in DONE -> outputs stable, InReady=0; RstN pulsed low mid-SHIFT -> OutValid never asserts, all outputs 0.
